// File: rtl/serial_tx_parity.sv
// Serial transmitter: 11-bit frame (start, 8 data LSB first, odd parity, stop)
// with a one-entry holding buffer so back-to-back frames leave no idle gap.
module serial_tx_parity #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_valid,
  input  logic [7:0] i_byte,
  output logic       o_ready,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done
);

  localparam logic [9:0] BAUD_LAST = 10'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t     state_q, state_d;
  logic [9:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic       par_q, par_d;
  logic       tx_q, tx_d;
  logic       accept;
  logic       baud_last;

  assign o_ready   = !hold_full_q;
  assign accept    = i_valid && !hold_full_q;
  assign baud_last = (baud_q == BAUD_LAST);
  assign o_busy    = (state_q != IDLE);
  assign o_done    = (state_q == STOP) && baud_last;
  assign o_tx      = tx_q;

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_last ? '0 : baud_q + 10'd1;
    bit_d       = bit_q;
    shift_d     = shift_q;
    par_d       = par_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tx_d        = tx_q;

    // A byte accepted while a frame is on the line parks in the holding buffer;
    // the STOP branch below overrides this when it can start the byte directly.
    if (state_q != IDLE && accept) begin
      hold_d      = i_byte;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (accept) begin
          state_d = START;
          shift_d = i_byte;
          par_d   = ~^i_byte;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_last) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (baud_last) begin
          if (bit_q == 3'd7) begin
            state_d = PARITY;
            tx_d    = par_q;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (baud_last) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (baud_last) begin
          if (hold_full_q) begin
            state_d     = START;
            shift_d     = hold_q;
            par_d       = ~^hold_q;
            hold_full_d = 1'b0;
            tx_d        = 1'b0;
          end else if (accept) begin
            state_d     = START;
            shift_d     = i_byte;
            par_d       = ~^i_byte;
            hold_full_d = 1'b0;
            tx_d        = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      par_q       <= 1'b0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      par_q       <= par_d;
      tx_q        <= tx_d;
    end
  end

endmodule

// File: doc/serial_tx_parity.md
SERIAL_TX_PARITY -- requirements
Module: serial_tx_parity

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 1, number of clk cycles each frame bit is driven on o_tx (legal range 1..1023).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: i_valid  input  1  byte offered on i_byte this cycle.
REQ-005 Port: i_byte  input  8  byte to transmit.
REQ-006 Port: o_ready  output  1  module can accept a byte this cycle.
REQ-007 Port: o_tx  output  1  serial line; idle level 1.
REQ-008 Port: o_busy  output  1  frame currently on the line.
REQ-009 Port: o_done  output  1  one-cycle pulse at frame completion.

Function
REQ-010 Frame SHALL be 11 bits, in order: start (0), data b0..b7 LSB first, parity, stop (1).
REQ-011 Parity bit SHALL be odd parity: the 8 data bits plus parity SHALL contain an odd number of 1s (parity = XNOR-reduce of the byte).
REQ-012 Handshake: a byte SHALL be accepted on any rising edge where i_valid && o_ready; i_byte is ignored otherwise.
REQ-013 Storage: one active shift register plus a one-entry holding buffer.
- o_ready = holding buffer empty.
- o_ready SHALL be combinationally independent of i_valid.
REQ-014 Acceptance in IDLE SHALL load the active register directly; o_tx SHALL drive the start bit from the next cycle (latency 1 cycle).
REQ-015 Acceptance while busy SHALL fill the holding buffer, dropping o_ready until that byte moves to the active register.
REQ-016 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-017 A bit counter (0..7) SHALL index DATA bits.
REQ-018 A baud counter SHALL hold every state for exactly CLKS_PER_BIT cycles; a full frame SHALL therefore last 11*CLKS_PER_BIT cycles.
REQ-019 Transitions:
- IDLE->START on accept.
- START->DATA.
- DATA->DATA until bit 7 completes, then ->PARITY.
- PARITY->STOP.
- STOP->START if the holding buffer is full (or an accept occurs in that last cycle), else STOP->IDLE.
REQ-020 Back-to-back frames SHALL have zero idle cycles between the stop bit and the next start bit.
REQ-021 On the STOP->START transition the holding buffer SHALL move into the active register and o_ready SHALL return to 1 the same edge.
REQ-022 o_done SHALL be 1 for exactly one cycle: the last cycle of each stop bit.
REQ-023 o_busy SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-024 o_tx SHALL be 1 in IDLE and SHALL be registered (glitch-free).
REQ-025 Simultaneous accept and frame end in STOP's last cycle: the new byte SHALL start next cycle with no gap and SHALL not be lost.

Reset
REQ-026 While rst_n=0, asynchronously and regardless of clk:
- o_tx=1, o_ready=1, o_busy=0, o_done=0.
- State=IDLE; counters=0; holding buffer empty.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately; any buffered byte SHALL be discarded.
REQ-028 After rst_n deasserts, the first accept SHALL behave as from IDLE (REQ-014).

Verification
REQ-029 CLKS_PER_BIT=1, send 0xA5 once -> o_tx over 11 cycles after accept = 0,1,0,1,0,0,1,0,1,1,1; o_done high in cycle 11 only; o_tx=1 afterward.
REQ-030 CLKS_PER_BIT=1, send 0x07 -> parity bit 0, frame 0,1,1,1,0,0,0,0,0,0,1.
REQ-031 CLKS_PER_BIT=1, hold i_valid with 0x00 then 0x01 -> o_ready low after second accept; second start bit immediately follows first stop bit; parities 1 then 0; two o_done pulses 11 cycles apart.
REQ-032 CLKS_PER_BIT=4, send 0xFF -> each bit held 4 cycles; parity 1; frame 44 cycles; o_done in cycle 44 only.
REQ-033 Assert rst_n=0 during DATA bit 3 with a byte buffered -> o_tx=1, o_ready=1, o_busy=0 immediately; no o_done; buffered byte never transmitted.
REQ-034 Scoreboard check: loop the output into the team's odd-parity serial receiver with 256 random bytes at CLKS_PER_BIT=1 -> every byte received intact, one done per frame.
